// File: rtl/instr_encoder_pkg.sv
// Shared instruction-word layout and loader FSM encoding.
// The decode stage imports the same field constants so packing and unpacking cannot drift apart.
package instr_encoder_pkg;

    localparam int INSTR_W  = 16;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int FLAG_BIT = 8;
    localparam int RA_MSB   = 7;
    localparam int RA_LSB   = 5;
    localparam int RB_MSB   = 4;
    localparam int RB_LSB   = 2;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Register form leaves bits [1:0] at zero.
    function automatic logic [INSTR_W-1:0] encode_instr(
        input logic [3:0] op,
        input logic [2:0] rd,
        input logic [2:0] ra,
        input logic [2:0] rb,
        input logic [7:0] imm,
        input logic       imm_form,
        input logic       flag
    );
        logic [INSTR_W-1:0] w;
        w                  = '0;
        w[OP_MSB:OP_LSB]   = op;
        w[RD_MSB:RD_LSB]   = rd;
        w[FLAG_BIT]        = flag;
        if (imm_form) begin
            w[IMM_MSB:IMM_LSB] = imm;
        end else begin
            w[RA_MSB:RA_LSB]   = ra;
            w[RB_MSB:RB_LSB]   = rb;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Single-clock FIFO with registered storage and pointer-based full/empty.
// Head is visible combinationally; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs instruction fields into 16-bit words, buffers them, writes them to consecutive addresses.
// Words reach memory one cycle after acceptance at the earliest; in_ready drops when the FIFO fills or the job quota is met.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [2:0]        rD_select,
    input  logic [2:0]        rA_select,
    input  logic [2:0]        rB_select,
    input  logic [7:0]        immediate,
    input  logic              imm_form,
    input  logic              flag,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    acc_cnt;
    logic [CNT_W-1:0]    wr_cnt;

    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [INSTR_W-1:0]  head_dat;
    logic [INSTR_W-1:0]  enc_word;

    assign enc_word = encode_instr(op, rD_select, rA_select, rB_select,
                                   immediate, imm_form, flag);

    // No full-bypass: a same-cycle pop does not reopen a full FIFO.
    assign in_ready  = (state == ST_LOAD) && !fifo_full && (acc_cnt < len_q);
    assign push      = in_valid && in_ready;
    assign pop       = !fifo_empty && mem_ready;

    assign mem_we    = !fifo_empty;
    assign mem_addr  = addr_q;
    assign mem_wdata = fifo_empty ? '0 : head_dat;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (enc_word),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr_q  <= base_addr;
                        len_q   <= {1'b0, length};
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        busy    <= 1'b1;
                        if (length == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (push) begin
                        acc_cnt <= acc_cnt + CNT_ONE;
                    end
                    if (pop) begin
                        addr_q <= addr_q + ADDR_ONE;
                        wr_cnt <= wr_cnt + CNT_ONE;
                        if (wr_cnt + CNT_ONE == len_q) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for the instruction loader: encoding, backpressure, address wrap, length 0, ignored start, async reset.
module tb_instr_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] length;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [2:0]        rD_select;
    logic [2:0]        rA_select;
    logic [2:0]        rB_select;
    logic [7:0]        immediate;
    logic              imm_form;
    logic              flag;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rD_select (rD_select),
        .rA_select (rA_select),
        .rB_select (rB_select),
        .immediate (immediate),
        .imm_form  (imm_form),
        .flag      (flag),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          done_cnt = 0;

    // Inputs change at posedge+1, so a negedge sample predicts the next edge's write.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && mem_ready) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_job(input logic [7:0] b, input logic [7:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic set_fields(input logic [3:0] o, input logic [2:0] rd, input logic [2:0] ra,
                              input logic [2:0] rb, input logic [7:0] im, input logic fm,
                              input logic fl);
        op = o; rD_select = rd; rA_select = ra; rB_select = rb;
        immediate = im; imm_form = fm; flag = fl;
    endtask

    task automatic send_imm(input string tag, input logic [3:0] o, input logic [2:0] rd,
                            input logic [7:0] im, input logic fl);
        logic got_rdy;
        got_rdy = 1'b0;
        set_fields(o, rd, 3'd0, 3'd0, im, 1'b1, fl);
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (in_ready) begin
                got_rdy = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_accept"}, got_rdy, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done"}, seen, 1'b1);
        tick();
    endtask

    function automatic logic [15:0] imm_word(input logic [3:0] o, input logic [2:0] rd,
                                             input logic fl, input logic [7:0] im);
        return {o, rd, fl, im};
    endfunction

    logic [15:0] bp_exp[6];
    int          idx;
    logic        was_rdy;
    logic        bp_bad;

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0;
        mem_ready = 1'b0;
        set_fields(4'h0, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        tick();

        // Register form, single write.
        mem_ready = 1'b1;
        clear_log();
        start_job(8'h10, 8'd1);
        check("reg_in_ready", in_ready, 1'b1);
        set_fields(4'hA, 3'd3, 3'd5, 3'd6, 8'hFF, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("reg_mem_we", mem_we, 1'b1);
        check("reg_mem_addr", mem_addr, 8'h10);
        check("reg_mem_wdata", mem_wdata, 16'hA6B8);
        check("reg_done_early", done, 1'b0);
        tick();
        check("reg_done", done, 1'b1);
        check("reg_busy_in_done", busy, 1'b1);
        check("reg_we_after", mem_we, 1'b0);
        tick();
        check("reg_done_clr", done, 1'b0);
        check("reg_busy_clr", busy, 1'b0);
        check("reg_nwrites", wr_addr_q.size(), 1);
        check("reg_done_cnt", done_cnt, 1);

        // Immediate form.
        clear_log();
        start_job(8'h20, 8'd1);
        send_imm("imm", 4'h3, 3'd7, 8'h5C, 1'b1);
        check("imm_mem_wdata", mem_wdata, 16'h3F5C);
        check("imm_mem_addr", mem_addr, 8'h20);
        wait_done("imm");

        // Backpressure: memory stalled, producer always valid.
        for (int i = 0; i < 6; i++)
            bp_exp[i] = imm_word(4'(i + 1), 3'(i), i[0], 8'(8'h40 + i));
        clear_log();
        mem_ready = 1'b0;
        start_job(8'h30, 8'd6);
        idx = 0;
        bp_bad = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_fields(4'(idx + 1), 3'(idx), 3'd0, 3'd0, 8'(8'h40 + idx), 1'b1, idx[0]);
            was_rdy = in_ready;
            tick();
            if (was_rdy) idx++;
            if (mem_we && (mem_addr !== 8'h30 || mem_wdata !== bp_exp[0])) bp_bad = 1'b1;
        end
        check("bp_accepted", idx, DEPTH);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_mem_we", mem_we, 1'b1);
        check("bp_stable", bp_bad, 1'b0);
        check("bp_no_writes", wr_addr_q.size(), 0);
        mem_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 6; c++) begin
            set_fields(4'(idx + 1), 3'(idx), 3'd0, 3'd0, 8'(8'h40 + idx), 1'b1, idx[0]);
            was_rdy = in_ready;
            tick();
            if (was_rdy) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", idx, 6);
        wait_done("bp");
        check("bp_nwrites", wr_addr_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_addr_q.size()) begin
                check($sformatf("bp_addr%0d", i), wr_addr_q[i], 8'(8'h30 + i));
                check($sformatf("bp_data%0d", i), wr_data_q[i], bp_exp[i]);
            end
        end

        // Address wrap with a start pulse mid-job.
        clear_log();
        start_job(8'hFE, 8'd3);
        send_imm("wrap0", 4'h1, 3'd1, 8'h11, 1'b0);
        start = 1'b1; base_addr = 8'h80; length = 8'd1;
        tick();
        start = 1'b0;
        check("wrap_busy_mid", busy, 1'b1);
        send_imm("wrap1", 4'h2, 3'd2, 8'h22, 1'b1);
        send_imm("wrap2", 4'h3, 3'd3, 8'h33, 1'b0);
        wait_done("wrap");
        check("wrap_nwrites", wr_addr_q.size(), 3);
        if (wr_addr_q.size() == 3) begin
            check("wrap_addr0", wr_addr_q[0], 8'hFE);
            check("wrap_addr1", wr_addr_q[1], 8'hFF);
            check("wrap_addr2", wr_addr_q[2], 8'h00);
            check("wrap_data2", wr_data_q[2], 16'h3633);
        end
        check("wrap_done_cnt", done_cnt, 1);

        // Zero-length job.
        clear_log();
        start_job(8'h60, 8'd0);
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b1);
        check("len0_in_ready", in_ready, 1'b0);
        check("len0_we", mem_we, 1'b0);
        tick();
        check("len0_done_clr", done, 1'b0);
        check("len0_nwrites", wr_addr_q.size(), 0);

        // Reset mid-job with two words still buffered.
        clear_log();
        mem_ready = 1'b0;
        start_job(8'h50, 8'd5);
        send_imm("rm0", 4'h5, 3'd0, 8'hA0, 1'b0);
        send_imm("rm1", 4'h5, 3'd1, 8'hA1, 1'b0);
        send_imm("rm2", 4'h5, 3'd2, 8'hA2, 1'b0);
        send_imm("rm3", 4'h5, 3'd3, 8'hA3, 1'b0);
        mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        check("rm_nwrites", wr_addr_q.size(), 2);
        check("rm_we_pre", mem_we, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("rm_we_async", mem_we, 1'b0);
        check("rm_busy_async", busy, 1'b0);
        check("rm_addr_async", mem_addr, 8'h00);
        check("rm_wdata_async", mem_wdata, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        clear_log();
        mem_ready = 1'b1;
        start_job(8'h40, 8'd2);
        send_imm("new0", 4'hC, 3'd4, 8'h77, 1'b1);
        send_imm("new1", 4'hD, 3'd5, 8'h88, 1'b0);
        wait_done("new");
        check("new_nwrites", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            check("new_addr0", wr_addr_q[0], 8'h40);
            check("new_data0", wr_data_q[0], 16'hC977);
            check("new_addr1", wr_addr_q[1], 8'h41);
            check("new_data1", wr_data_q[1], 16'hDA88);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
